// File: rtl/abr_prim_pulse_req_tx.sv
// Pulse-crossing transmitter: turns event pulses into a four-phase req/ack
// handshake, queueing pulses that arrive while a handshake is in flight.

module abr_prim_flop_2sync #(
  parameter int unsigned Width = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= ResetValue;
      s2_q <= ResetValue;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

module abr_prim_pulse_req_tx #(
  parameter int unsigned CntWidth = 4,
  parameter bit          EnSync   = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pulse_i,
  output logic                req_o,
  input  logic                ack_i,
  output logic                busy_o,
  output logic [CntWidth-1:0] pending_o,
  output logic                done_o,
  output logic                overflow_o
);
  typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

  localparam logic [CntWidth-1:0] CntMax = '1;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                ack_s;
  logic                free, launch, consume;

  generate
    if (EnSync) begin : g_sync
      abr_prim_flop_2sync #(.Width(1), .ResetValue(1'b0)) u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ack_i),
        .q_o   (ack_s)
      );
    end else begin : g_nosync
      assign ack_s = ack_i;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovf_d   = 1'b0;
    free    = 1'b0;

    unique case (state_q)
      StIdle: free = 1'b1;
      StReq:  if (ack_s) state_d = StRel;
      StRel: begin
        if (!ack_s) begin
          done_d = 1'b1;
          free   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A free slot launches either the incoming pulse or the oldest queued one.
    launch  = free && (pulse_i || (cnt_q != '0));
    consume = launch && (cnt_q != '0);
    if (free) state_d = launch ? StReq : StIdle;

    if (pulse_i) begin
      if (!launch) begin
        if (cnt_q == CntMax) ovf_d = 1'b1;
        else                 cnt_d = cnt_q + 1'b1;
      end
    end else if (consume) begin
      cnt_d = cnt_q - 1'b1;
    end

    // req is a real flop so the level crossing to the peer is glitch-free.
    req_d  = (state_d == StReq);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign req_o      = req_q;
  assign busy_o     = busy_q;
  assign pending_o  = cnt_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
endmodule

// File: doc/abr_prim_pulse_req_tx.md
Name: abr_prim_pulse_req_tx

Overview:
Transmit side of a pulse-crossing channel. It converts single-cycle event pulses into a four-phase req/ack level handshake toward a destination domain. The destination recovers events from `req_o` with an edge detector/synchronizer and returns `ack_i`. Pulses that arrive while a handshake is outstanding are counted and replayed back-to-back, so no event is lost unless the counter saturates.

Parameters:
- CntWidth, 4, width of the pending-event counter; maximum backlog is 2^CntWidth-1.
- EnSync, 1'b1, when 1 `ack_i` passes through an internal 2-flop synchronizer (`abr_prim_flop_2sync`, reset value 0); when 0 `ack_i` is used directly and is already in this clock domain.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- pulse_i  input  1  event pulse; each cycle it is high counts as one event.
- req_o  output  1  four-phase request level to the destination.
- ack_i  input  1  acknowledge level from the destination; asynchronous when EnSync=1.
- busy_o  output  1  high whenever the FSM is not IDLE.
- pending_o  output  CntWidth  queued events not yet launched.
- done_o  output  1  one-cycle pulse when a handshake completes (ack seen low again).
- overflow_o  output  1  one-cycle pulse when an event is dropped.

Behaviour:
- Reset: one clock with rst_i=1 sets everything to zero.
  - FSM state = IDLE.
  - req_o=0, busy_o=0, pending_o=0, done_o=0, overflow_o=0.
  - Synchronizer flops are cleared.
- Reset mid-handshake: req_o is 0 on the cycle after the reset edge and the queued events are discarded. Peer recovery is the system's responsibility.
- ack_s: the synchronized ack when EnSync=1, otherwise ack_i. This adds 2 cycles of ack latency when EnSync=1.
- FSM states: IDLE, REQ, REL. req_o is registered and is 1 only in REQ.
  - IDLE: `launch = pulse_i | (cnt != 0)`. When launch is true, go to REQ; req_o is 1 in the next cycle.
  - REQ: hold until ack_s==1, then go to REL.
  - REL: hold until ack_s==0.
    - On that cycle done_o=1 (registered, so it is high in the cycle after the condition).
    - Then apply the same launch test as IDLE: if true go directly to REQ, otherwise go to IDLE.
  - req_o never changes while the matching ack phase is still outstanding.
- Latency: a pulse in IDLE with cnt=0 gives req_o=1 on the next cycle. With back-to-back replay, req_o falls in REL and rises again after 1 cycle low.
- Counter update, evaluated each cycle. `consume` = a launch is taken (IDLE or REL exit) and cnt!=0.
  - pulse_i=1 and consume=1: cnt unchanged; the new pulse is queued and the oldest is launched.
  - pulse_i=1, no launch from cnt, and the pulse is not launched directly: cnt+1.
    - If cnt is already 2^CntWidth-1, cnt holds (saturates) and overflow_o pulses the next cycle.
  - pulse_i=0 and consume=1: cnt-1.
  - Launch on a pulse with cnt=0: the pulse is consumed directly and cnt stays 0.
  - pulse_i is ignored while rst_i=1.
- pending_o = cnt (registered).
- busy_o = (state != IDLE) (registered).
- done_o and overflow_o are single-cycle pulses, never held.
- An ack_s rise while in IDLE or REL is protocol-illegal: ignored, no state change.

Test Plan:
- Single event: reset; pulse_i=1 for 1 cycle; ack_i raised 3 cycles after req_o and dropped 3 cycles after req_o falls (EnSync=1).
  - Expect req_o 0→1 one cycle after the pulse and busy_o=1.
  - Expect req_o→0 two cycles after ack_i rises.
  - Expect done_o one pulse 2–3 cycles after ack_i falls, then busy_o=0 and pending_o=0.
- Burst: 5 consecutive pulse cycles while the first handshake is in flight.
  - Expect pending_o to reach 4.
  - Expect 5 complete handshakes, 5 done_o pulses, and pending_o back to 0.
- Overflow (CntWidth=2): hold req pending, issue 6 pulses.
  - Expect pending_o to saturate at 3 and overflow_o to pulse twice.
  - After draining, exactly 4 handshakes and 4 done_o pulses.
- Simultaneous pulse and consume: pulse_i=1 on the REL exit cycle with pending_o=2.
  - Expect pending_o to stay at 2 and req_o to rise the cycle after the exit.
- Reset mid-handshake: assert rst_i for 1 cycle while in REQ with pending_o=3.
  - Next cycle expect req_o=0, pending_o=0, busy_o=0.
  - A later pulse starts a fresh handshake.
- EnSync=0: ack_i driven synchronously.
  - Expect REQ→REL one cycle after ack_i=1, with no 2-cycle synchronizer delay.
  - Expect done_o one cycle after ack_i=0.
